// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the opcode decoder. Holds the PC, issues one
// instruction-memory request at a time over a req/gnt/rvalid interface,
// registers the returned word and presents it downstream through a
// valid/ready handshake. A taken branch/jump (redirect) reloads the PC and
// throws away any fetch that is still in flight.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request (high only in REQ)
//   imem_addr    fetch address (current PC)
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  read data valid (only looked at in WAIT)
//   imem_rdata   instruction word from memory
//   instr_valid  instr / instr_pc / opcode are valid
//   instr_ready  downstream accepts this cycle
//   instr        registered instruction
//   instr_pc     address the registered instruction came from
//   opcode       top 4 bits of instr
//   redirect     taken branch/jump, highest priority in every state
//   redirect_pc  new fetch target
//   stall_cnt    (only with FETCH_STALL_CNT_EN) saturating count of cycles
//                spent waiting on gnt, rvalid or ready
//
// Optional feature macro: FETCH_STALL_CNT_EN
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned          PC_W     = 16,
   parameter int unsigned          INSTR_W  = 16,
   parameter logic [PC_W-1:0]      RESET_PC = '0,
   parameter int unsigned          PC_INC   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic [3:0]         opcode,
`ifdef FETCH_STALL_CNT_EN
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [31:0]        stall_cnt
`else
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   fetch_state_t        state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [PC_W-1:0]     issued_pc_q, issued_pc_d;
   logic                drop_q, drop_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
   logic                valid_q, valid_d;

   // State and datapath registers. Everything returns to its reset value
   // the moment rst_n falls, so a response still travelling back from
   // memory simply lands in IDLE and is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         issued_pc_q <= RESET_PC;
         drop_q      <= 1'b0;
         instr_q     <= '0;
         instr_pc_q  <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issued_pc_q <= issued_pc_d;
         drop_q      <= drop_d;
         instr_q     <= instr_d;
         instr_pc_q  <= instr_pc_d;
         valid_q     <= valid_d;
      end
   end

   // Next-state logic. Redirect is checked first in every state: it reloads
   // the PC, kills instr_valid, and if a fetch is (or is becoming) in flight
   // it sets drop so that exactly one stale response gets swallowed in WAIT.
   // A handshake seen in the same cycle as a redirect is deliberately not
   // acted on, so a granted fetch does not advance the PC and a downstream
   // ready does not count as consumption.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issued_pc_d = issued_pc_q;
      drop_d      = drop_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      valid_d     = valid_q;

      if (redirect) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end

         REQ: begin
            if (redirect) begin
               if (imem_gnt) begin
                  drop_d  = 1'b1;
                  state_d = WAIT;
               end
            end else if (imem_gnt) begin
               issued_pc_d = pc_q;
               pc_d        = pc_q + PC_W'(PC_INC);
               state_d     = WAIT;
            end
         end

         WAIT: begin
            if (redirect) begin
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  instr_d    = imem_rdata;
                  instr_pc_d = issued_pc_q;
                  valid_d    = 1'b1;
                  state_d    = HOLD;
               end
            end
         end

         HOLD: begin
            if (redirect || instr_ready) begin
               valid_d = 1'b0;
               state_d = REQ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory side outputs come straight from state and PC. The PC only moves
   // on gnt or redirect, which keeps the address stable while a request is
   // waiting to be granted.
   always_comb begin
      imem_req    = (state_q == REQ);
      imem_addr   = pc_q;
      instr_valid = valid_q;
      instr       = instr_q;
      instr_pc    = instr_pc_q;
      opcode      = instr_q[INSTR_W-1 -: 4];
   end

`ifdef FETCH_STALL_CNT_EN
   logic        stall_cond;
   logic [31:0] stall_cnt_q;

   // A stall cycle is any cycle where the current state is waiting on the
   // other side of one of its handshakes.
   always_comb begin
      stall_cond = ((state_q == REQ)  && !imem_gnt)    ||
                   ((state_q == WAIT) && !imem_rvalid) ||
                   ((state_q == HOLD) && !instr_ready);
   end

   // Stall counter, saturating at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall_cond && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed testbench for fetch_unit. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, half a cycle away from the
// rising edge where the design updates. A second instance with
// RESET_PC = 16'hFFFF covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [3:0]  opcode;
   logic        redirect;
   logic [15:0] redirect_pc;

   logic        w_rst_n;
   logic        w_imem_req;
   logic [15:0] w_imem_addr;
   logic        w_imem_gnt;
   logic        w_imem_rvalid;
   logic [15:0] w_imem_rdata;
   logic        w_instr_valid;
   logic        w_instr_ready;
   logic [15:0] w_instr;
   logic [15:0] w_instr_pc;
   logic [3:0]  w_opcode;
   logic        w_redirect;
   logic [15:0] w_redirect_pc;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] w_stall_cnt;
`endif

   int checks;
   int errors;
   int cycle;
   int first_valid_cycle;

   fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_INC(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
`ifdef FETCH_STALL_CNT_EN
      .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
`else
      .redirect(redirect), .redirect_pc(redirect_pc)
`endif
   );

   fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF), .PC_INC(1)) dut_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_imem_gnt),
      .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
      .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
      .instr(w_instr), .instr_pc(w_instr_pc), .opcode(w_opcode),
`ifdef FETCH_STALL_CNT_EN
      .redirect(w_redirect), .redirect_pc(w_redirect_pc), .stall_cnt(w_stall_cnt)
`else
      .redirect(w_redirect), .redirect_pc(w_redirect_pc)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure fetch throughput.
   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   // Advance one rising edge and land on the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++; if (instr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0000", instr); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
      checks++; if (opcode !== 4'h0) begin errors++; $display("[TB] FAIL reset_opcode: got %h expected 0", opcode); end
      rst_n = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
   endtask

   task automatic test_zero_wait();
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL zw_addr0: got %h expected 0000", imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL zw_wait_req: got %b expected 0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h0123;
      tick();
      imem_rvalid = 1'b0;
      first_valid_cycle = cycle;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid0: got %b expected 1", instr_valid); end
      checks++; if (instr !== 16'h0123) begin errors++; $display("[TB] FAIL zw_instr0: got %h expected 0123", instr); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL zw_pc0: got %h expected 0000", instr_pc); end
      checks++; if (opcode !== 4'h0) begin errors++; $display("[TB] FAIL zw_opcode0: got %h expected 0", opcode); end
      instr_ready = 1'b1;
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_valid_drop: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL zw_req1: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 16'h0001) begin errors++; $display("[TB] FAIL zw_addr1: got %h expected 0001", imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h4567;
      tick();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid1: got %b expected 1", instr_valid); end
      checks++; if (instr_pc !== 16'h0001) begin errors++; $display("[TB] FAIL zw_pc1: got %h expected 0001", instr_pc); end
      checks++; if (opcode !== 4'h4) begin errors++; $display("[TB] FAIL zw_opcode1: got %h expected 4", opcode); end
      checks++; if ((cycle - first_valid_cycle) !== 3) begin errors++; $display("[TB] FAIL zw_period: got %0d expected 3", cycle - first_valid_cycle); end
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      checks++; if (imem_addr !== 16'h0002) begin errors++; $display("[TB] FAIL bp_addr: got %h expected 0002", imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hA5C3;
      tick();
      imem_rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, instr_valid); end
         checks++; if (instr !== 16'hA5C3) begin errors++; $display("[TB] FAIL bp_instr[%0d]: got %h expected a5c3", i, instr); end
         checks++; if (instr_pc !== 16'h0002) begin errors++; $display("[TB] FAIL bp_pc[%0d]: got %h expected 0002", i, instr_pc); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req[%0d]: got %b expected 0", i, imem_req); end
         tick();
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 16'h0003) begin errors++; $display("[TB] FAIL bp_resume_addr: got %h expected 0003", imem_addr); end
   endtask

   task automatic test_redirect_wait();
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rw_req: got %b expected 0", imem_req); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_valid_pre: got %b expected 0", instr_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h7FFF;
      tick();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_valid_post: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rw_req_next: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL rw_addr: got %h expected 0040", imem_addr); end
   endtask

   task automatic test_redirect_gnt();
      redirect    = 1'b1;
      redirect_pc = 16'h0005;
      tick();
      redirect = 1'b0;
      checks++; if (imem_addr !== 16'h0005) begin errors++; $display("[TB] FAIL rg_addr5: got %h expected 0005", imem_addr); end
      imem_gnt    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0009;
      tick();
      imem_gnt    = 1'b0;
      redirect    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h1234;
      tick();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rg_drop_valid: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rg_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 16'h0009) begin errors++; $display("[TB] FAIL rg_addr9: got %h expected 0009", imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h2222;
      tick();
      imem_rvalid = 1'b0;
      checks++; if (instr_pc !== 16'h0009) begin errors++; $display("[TB] FAIL rg_instr_pc: got %h expected 0009", instr_pc); end
      checks++; if (opcode !== 4'h2) begin errors++; $display("[TB] FAIL rg_opcode: got %h expected 2", opcode); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++; if (imem_addr !== 16'h000A) begin errors++; $display("[TB] FAIL rg_addr10: got %h expected 000a", imem_addr); end
   endtask

   task automatic test_reset_mid();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rm_addr: got %h expected 0000", imem_addr); end
      checks++; if (instr !== 16'h0000) begin errors++; $display("[TB] FAIL rm_instr: got %h expected 0000", instr); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL rm_instr_pc: got %h expected 0000", instr_pc); end
      checks++; if (opcode !== 4'h0) begin errors++; $display("[TB] FAIL rm_opcode: got %h expected 0", opcode); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_req: got %b expected 0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hBEEF;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_late_valid: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rm_restart_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rm_restart_addr: got %h expected 0000", imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h3333;
      tick();
      imem_rvalid = 1'b0;
      checks++; if (instr !== 16'h3333) begin errors++; $display("[TB] FAIL rm_instr_after: got %h expected 3333", instr); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL rm_pc_after: got %h expected 0000", instr_pc); end
   endtask

   task automatic test_redirect_hold();
      redirect    = 1'b1;
      redirect_pc = 16'h0020;
      instr_ready = 1'b1;
      tick();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rh_valid: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rh_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 16'h0020) begin errors++; $display("[TB] FAIL rh_addr: got %h expected 0020", imem_addr); end
   endtask

   task automatic test_pc_wrap();
      w_rst_n = 1'b1;
      tick();
      checks++; if (w_imem_addr !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected ffff", w_imem_addr); end
      w_imem_gnt = 1'b1;
      tick();
      w_imem_gnt    = 1'b0;
      w_imem_rvalid = 1'b1;
      w_imem_rdata  = 16'hF00D;
      tick();
      w_imem_rvalid = 1'b0;
      checks++; if (w_instr_pc !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_instr_pc: got %h expected ffff", w_instr_pc); end
      checks++; if (w_opcode !== 4'hF) begin errors++; $display("[TB] FAIL wrap_opcode: got %h expected f", w_opcode); end
      w_instr_ready = 1'b1;
      tick();
      w_instr_ready = 1'b0;
      checks++; if (w_imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 0000", w_imem_addr); end
   endtask

   // Test sequence: hold both instances in reset, then run each scenario
   // back to back on the main instance before the wrap-around check.
   initial begin
      checks        = 0;
      errors        = 0;
      cycle         = 0;
      rst_n         = 1'b0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 16'h0000;
      instr_ready   = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = 16'h0000;
      w_rst_n       = 1'b0;
      w_imem_gnt    = 1'b0;
      w_imem_rvalid = 1'b0;
      w_imem_rdata  = 16'h0000;
      w_instr_ready = 1'b0;
      w_redirect    = 1'b0;
      w_redirect_pc = 16'h0000;
      @(negedge clk);
      @(negedge clk);

      test_reset();
      test_zero_wait();
      test_backpressure();
      test_redirect_wait();
      test_redirect_gnt();
      test_reset_mid();
      test_redirect_hold();
      test_pc_wrap();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
